// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - seven-segment scan bus monitor: per-digit stability filter, decode, frame assembly
module seg7_scan_decoder #(
  parameter int STABLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  output logic [15:0] value,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        stale
);

  localparam int CW = ($clog2(STABLE_CYCLES + 1) > 8) ? $clog2(STABLE_CYCLES + 1) : 8;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] STABLE_MAX  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CAPTURE_AT  = CW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

  logic [3:0]    an_q, an_p;
  logic [6:0]    seg_q, seg_p;
  logic [CW-1:0] cnt, cnt_next;
  logic [3:0]    slot_code [4];
  logic [3:0]    slot_unk, unk_next;
  logic [3:0]    seen, seen_next;
  logic [TW-1:0] st_cnt;
  logic          sel_valid, same, capture, complete;
  logic [1:0]    sel_idx;
  logic [3:0]    dec_code;
  logic          dec_unk;

  // Returns {unknown, code}; unknown patterns decode to code 0.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b1000000: decode = 5'h00;
      7'b1111001: decode = 5'h01;
      7'b0100100: decode = 5'h02;
      7'b0110000: decode = 5'h03;
      7'b0011001: decode = 5'h04;
      7'b0010010: decode = 5'h05;
      7'b0000010: decode = 5'h06;
      7'b1111000: decode = 5'h07;
      7'b0000000: decode = 5'h08;
      7'b0011000: decode = 5'h09;
      7'b0001000: decode = 5'h0a;
      7'b0000011: decode = 5'h0b;
      7'b1000110: decode = 5'h0c;
      7'b0100001: decode = 5'h0d;
      7'b0000100: decode = 5'h0e;
      7'b1111111: decode = 5'h0f;
      default:    decode = 5'h10;
    endcase
  endfunction

  assign {dec_unk, dec_code} = decode(seg_q);

  always_comb begin
    sel_valid = 1'b1;
    sel_idx   = 2'd0;
    case (an_q)
      4'b1110: sel_idx = 2'd0;
      4'b1101: sel_idx = 2'd1;
      4'b1011: sel_idx = 2'd2;
      4'b0111: sel_idx = 2'd3;
      default: sel_valid = 1'b0;
    endcase
  end

  assign same = (an_q == an_p) && (seg_q == seg_p);

  always_comb begin
    cnt_next = '0;
    if (sel_valid) begin
      if (!same)
        cnt_next = CW'(1);
      else if (cnt == STABLE_MAX)
        cnt_next = cnt;
      else
        cnt_next = cnt + 1'b1;
    end
  end

  // The counter trails the sample register by one cycle, so the dwell is
  // complete one count early; this keeps pin-to-capture at STABLE_CYCLES.
  assign capture  = sel_valid && (cnt_next == CAPTURE_AT);
  assign complete = (seen == 4'hF);

  always_comb begin
    seen_next = complete ? 4'h0 : seen;
    unk_next  = complete ? 4'h0 : slot_unk;
    if (capture) begin
      seen_next[sel_idx] = 1'b1;
      unk_next[sel_idx]  = dec_unk;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an_q        <= 4'hF;
      an_p        <= 4'hF;
      seg_q       <= 7'h7F;
      seg_p       <= 7'h7F;
      cnt         <= '0;
      seen        <= 4'h0;
      slot_unk    <= 4'h0;
      value       <= 16'h0000;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      st_cnt      <= '0;
      for (int i = 0; i < 4; i++)
        slot_code[i] <= 4'h0;
    end else begin
      an_q        <= an;
      seg_q       <= seg;
      an_p        <= an_q;
      seg_p       <= seg_q;
      cnt         <= cnt_next;
      seen        <= seen_next;
      slot_unk    <= unk_next;
      frame_valid <= complete;
      if (capture)
        slot_code[sel_idx] <= dec_code;
      if (complete) begin
        value     <= {slot_code[3], slot_code[2], slot_code[1], slot_code[0]};
        frame_err <= |slot_unk;
        st_cnt    <= '0;
      end else if (st_cnt != TIMEOUT_MAX) begin
        st_cnt <= st_cnt + 1'b1;
      end
    end
  end

  assign stale = (st_cnt == TIMEOUT_MAX);

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - randomized and directed bench for seg7_scan_decoder with a run-length reference model
module tb_seg7_scan_decoder;

  localparam int S = 8;
  localparam int T = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  an = 4'hF;
  logic [6:0]  seg = 7'h7F;
  logic [15:0] value;
  logic        frame_valid, frame_err, stale;

  always #5 clk = ~clk;

  seg7_scan_decoder #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .an(an), .seg(seg),
    .value(value), .frame_valid(frame_valid), .frame_err(frame_err), .stale(stale)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: display table, run length of identical samples, slots.
  logic [6:0]  pat_tab [16];
  logic [3:0]  m_last_an;
  logic [6:0]  m_last_seg;
  int          m_run;
  logic [3:0]  m_slot [4];
  logic [3:0]  m_unk, m_seen;
  logic [15:0] m_val;
  logic        m_err, m_fv;
  int          m_st;

  int          cyc = 0, t3 = 0, fv_cyc = 0, frames = 0;
  logic [15:0] last_val;
  logic        last_err, last_stale, fr_prev_stale, prev_stale;

  function automatic logic [4:0] ref_decode(input logic [6:0] s);
    for (int i = 0; i < 16; i++)
      if (pat_tab[i] == s) return {1'b0, 4'(i)};
    return 5'h10;
  endfunction

  function automatic int digit_of(input logic [3:0] a);
    logic [3:0] lows;
    lows = ~a;
    if ($countones(lows) != 1) return -1;
    for (int i = 0; i < 4; i++)
      if (lows[i]) return i;
    return -1;
  endfunction

  task automatic model_edge();
    logic [4:0] d;
    int idx;
    if (!rst_n) begin
      m_seen = 0; m_unk = 0; m_val = 0; m_err = 0; m_fv = 0; m_st = 0;
      for (int i = 0; i < 4; i++) m_slot[i] = 0;
      m_last_an = 4'hF; m_last_seg = 7'h7F; m_run = 1;
    end else begin
      m_fv = (m_seen == 4'hF);
      if (m_fv) begin
        m_val = {m_slot[3], m_slot[2], m_slot[1], m_slot[0]};
        m_err = |m_unk;
        m_seen = 0; m_unk = 0; m_st = 0;
      end else if (m_st < T) begin
        m_st++;
      end
      idx = digit_of(m_last_an);
      if (idx >= 0 && m_run == S - 1) begin
        d = ref_decode(m_last_seg);
        m_slot[idx] = d[3:0];
        m_unk[idx] = d[4];
        m_seen[idx] = 1'b1;
      end
      if (an == m_last_an && seg == m_last_seg) begin
        if (m_run < 1000) m_run++;
      end else begin
        m_run = 1; m_last_an = an; m_last_seg = seg;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    check("frame_valid", frame_valid, m_fv);
    check("stale", stale, m_st >= T);
    if (m_fv) begin
      check("value", value, m_val);
      check("frame_err", frame_err, m_err);
    end
    if (frame_valid) begin
      frames++; last_val = value; last_err = frame_err;
      last_stale = stale; fr_prev_stale = prev_stale; fv_cyc = cyc;
    end
    prev_stale = stale;
  endtask

  task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
    an = a; seg = s;
    repeat (n) step();
  endtask

  task automatic digit(input int i, input logic [6:0] s, input int hold, input int gap);
    logic [3:0] a;
    a = 4'b0001 << i;
    drive(~a, s, hold);
    drive(4'hF, 7'h7F, gap);
  endtask

  task automatic scan(input logic [15:0] v, input int hold, input int gap, input int bad);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) t3 = cyc;
      digit(i, (i == bad) ? 7'b1010101 : pat_tab[v[4*i +: 4]], hold, gap);
    end
  endtask

  task automatic do_reset(input int n);
    rst_n = 0; an = 4'hF; seg = 7'h7F;
    repeat (n) step();
    rst_n = 1;
  endtask

  initial begin
    int f0;
    pat_tab[0]  = 7'b1000000; pat_tab[1]  = 7'b1111001; pat_tab[2]  = 7'b0100100;
    pat_tab[3]  = 7'b0110000; pat_tab[4]  = 7'b0011001; pat_tab[5]  = 7'b0010010;
    pat_tab[6]  = 7'b0000010; pat_tab[7]  = 7'b1111000; pat_tab[8]  = 7'b0000000;
    pat_tab[9]  = 7'b0011000; pat_tab[10] = 7'b0001000; pat_tab[11] = 7'b0000011;
    pat_tab[12] = 7'b1000110; pat_tab[13] = 7'b0100001; pat_tab[14] = 7'b0000100;
    pat_tab[15] = 7'b1111111;
    prev_stale = 0;

    do_reset(3);
    check("rst_value", value, 16'h0000);
    check("rst_frame_valid", frame_valid, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_stale", stale, 1'b0);

    // Clean scan; long enough that stale is already up when the frame lands.
    f0 = frames;
    scan(16'h4321, 20, 4, -1);
    check("clean_count", frames - f0, 1);
    check("clean_value", last_val, 16'h4321);
    check("clean_err", last_err, 1'b0);
    check("clean_latency", fv_cyc - t3, 9);
    check("stale_before_frame", fr_prev_stale, 1'b1);
    check("stale_drop", last_stale, 1'b0);

    drive(4'hF, 7'h7F, 60);
    check("stale_hold", stale, 1'b1);
    drive(4'hF, 7'h7F, 5);
    check("stale_stays", stale, 1'b1);

    do_reset(2);
    scan(16'h0FBA, 12, 2, -1);
    check("letters_value", last_val, 16'h0FBA);
    check("letters_err", last_err, 1'b0);

    do_reset(2);
    scan(16'h4321, 12, 2, 2);
    check("unknown_nibble", last_val[11:8], 4'h0);
    check("unknown_value", last_val, 16'h4021);
    check("unknown_err", last_err, 1'b1);
    scan(16'h8765, 12, 2, -1);
    check("after_unknown_err", last_err, 1'b0);
    check("after_unknown_value", last_val, 16'h8765);

    // Glitch on digit 1 must not replace its slot.
    do_reset(2);
    f0 = frames;
    digit(0, pat_tab[1], 20, 4);
    digit(1, pat_tab[2], 20, 4);
    digit(1, pat_tab[3], 5, 4);
    digit(2, pat_tab[4], 20, 4);
    digit(3, pat_tab[5], 20, 4);
    check("glitch_count", frames - f0, 1);
    check("glitch_value", last_val, 16'h5421);

    // Multiple lows never count as a digit.
    do_reset(2);
    f0 = frames;
    digit(0, pat_tab[9], 12, 2);
    digit(1, pat_tab[8], 12, 2);
    digit(2, pat_tab[7], 12, 2);
    drive(4'b1100, pat_tab[3], 30);
    drive(4'hF, 7'h7F, 4);
    check("multi_no_frame", frames - f0, 0);
    digit(3, pat_tab[6], 12, 4);
    check("multi_value", last_val, 16'h6789);

    // Reset mid-frame throws away the two captured digits.
    do_reset(2);
    f0 = frames;
    digit(0, pat_tab[1], 12, 2);
    digit(1, pat_tab[1], 12, 2);
    do_reset(2);
    digit(2, pat_tab[6], 12, 2);
    digit(3, pat_tab[5], 12, 2);
    check("midreset_no_frame", frames - f0, 0);
    digit(0, pat_tab[8], 12, 2);
    digit(1, pat_tab[7], 12, 4);
    check("midreset_count", frames - f0, 1);
    check("midreset_value", last_val, 16'h5678);

    for (int k = 0; k < 250; k++) begin
      int r, d;
      logic [3:0] a;
      logic [6:0] s;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        do_reset($urandom_range(1, 3));
      end else begin
        d = $urandom_range(0, 3);
        a = 4'b0001 << d;
        a = ~a;
        if (r < 8) a = 4'($urandom_range(0, 15));
        s = ($urandom_range(0, 9) < 8) ? pat_tab[$urandom_range(0, 15)] : 7'($urandom_range(0, 127));
        drive(a, s, $urandom_range(1, 14));
        drive(4'hF, 7'h7F, $urandom_range(0, 4));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
